// File: rtl/fp_to_fixed.sv
// fp_to_fixed: multi-cycle IEEE 754 single-precision to signed fixed-point converter.
// FSM: IDLE -> UNPACK -> SHIFT (one bit per cycle) -> ROUND -> OUTPUT -> IDLE.
// Optional build macro FP2FIX_ROUND_EN: round half away from zero instead of truncating.
module fp_to_fixed #(
    parameter int unsigned FRAC_BITS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] num_in,
    input  logic        start,
    output logic [31:0] int_out,
    output logic        done,
    output logic        ovf,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StUnpack, StShift, StRound, StOutput} state_e;

    localparam logic signed [10:0] FB = 11'(FRAC_BITS);

    state_e r_state;
    state_e w_state_nxt;

    logic [31:0] r_num;
    logic [31:0] r_mag;
    logic [31:0] r_res;
    logic [4:0]  r_cnt;
    logic        r_sign;
    logic        r_left;
    logic        r_sat;
`ifdef FP2FIX_ROUND_EN
    logic        r_guard;
`endif

    logic              w_sign;
    logic [7:0]        w_exp;
    logic [22:0]       w_frac;
    logic signed [10:0] w_e;
    logic signed [10:0] w_ef;
    logic signed [10:0] w_s;
    logic              w_sat_ovf;
    logic              w_zero_res;
    logic              w_skip;
    logic [31:0]       w_sat_val;
    logic [31:0]       w_rmag;

    // Decode the captured operand; only meaningful while in UNPACK.
    always_comb begin
        w_sign     = r_num[31];
        w_exp      = r_num[30:23];
        w_frac     = r_num[22:0];
        w_e        = $signed({3'b000, w_exp}) - 11'sd127;
        w_ef       = w_e + FB;
        w_s        = w_ef - 11'sd23;
        // -2^31 exactly fits, so that one case is not an overflow.
        w_sat_ovf  = (w_exp == 8'hFF) ||
                     ((w_exp != 8'h00) && (w_ef >= 11'sd31) &&
                      !(w_sign && (w_ef == 11'sd31) && (w_frac == 23'd0)));
        w_zero_res = (w_exp == 8'h00) || ((w_exp != 8'hFF) && (w_ef < -11'sd1));
        w_skip     = w_sat_ovf || w_zero_res || (w_s == 11'sd0);
        // NaN saturates positive regardless of sign.
        w_sat_val  = (((w_exp == 8'hFF) && (w_frac != 23'd0)) || !w_sign) ?
                     32'h7FFF_FFFF : 32'h8000_0000;
`ifdef FP2FIX_ROUND_EN
        // Right-shifted magnitude is below 2^24, so adding the guard cannot overflow.
        w_rmag     = r_mag + {31'd0, r_guard};
`else
        w_rmag     = r_mag;
`endif
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (start) w_state_nxt = StUnpack;
            StUnpack: w_state_nxt = w_skip ? StRound : StShift;
            StShift:  if (r_cnt == 5'd1) w_state_nxt = StRound;
            StRound:  w_state_nxt = StOutput;
            StOutput: w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    // Datapath: capture, unpack, shift, round and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_num   <= '0;
            r_mag   <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_left  <= 1'b0;
            r_sat   <= 1'b0;
`ifdef FP2FIX_ROUND_EN
            r_guard <= 1'b0;
`endif
            int_out <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) r_num <= num_in;
                end
                StUnpack: begin
                    r_sign  <= w_sign;
                    r_sat   <= w_sat_ovf;
                    r_res   <= w_sat_val;
                    r_left  <= ~w_s[10];
                    r_cnt   <= 5'(w_s[10] ? -w_s : w_s);
                    r_mag   <= w_zero_res ? 32'd0 : {8'd0, 1'b1, w_frac};
`ifdef FP2FIX_ROUND_EN
                    r_guard <= 1'b0;
`endif
                end
                StShift: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (r_left) begin
                        r_mag <= {r_mag[30:0], 1'b0};
                    end else begin
                        r_mag   <= {1'b0, r_mag[31:1]};
`ifdef FP2FIX_ROUND_EN
                        // Only the last bit shifted out matters for half-away rounding.
                        r_guard <= r_mag[0];
`endif
                    end
                end
                StRound: begin
                    if (!r_sat) r_res <= r_sign ? -w_rmag : w_rmag;
                end
                StOutput: begin
                    int_out <= r_res;
                    ovf     <= r_sat;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != StIdle);

endmodule

// File: tb/tb_fp_to_fixed.sv
// Bench for fp_to_fixed: two instances (FRAC_BITS=0 and 8) with a scoreboard per instance.
module tb_fp_to_fixed;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic [31:0] num   [2];
    logic [31:0] iout  [2];
    logic        done  [2];
    logic        ovf   [2];
    logic        busy  [2];

    int  cyc = 0;
    int  n_pass = 0;
    int  n_total = 0;
    sb_t q0[$];
    sb_t q1[$];
    logic [31:0] last_res [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_to_fixed #(.FRAC_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .num_in(num[0]), .start(start[0]),
        .int_out(iout[0]), .done(done[0]), .ovf(ovf[0]), .busy(busy[0])
    );

    fp_to_fixed #(.FRAC_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .num_in(num[1]), .start(start[1]),
        .int_out(iout[1]), .done(done[1]), .ovf(ovf[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference conversion: value = {1,frac} * 2^(e-23+fb), saturating / flushing at the ends.
    function automatic logic [31:0] model(input logic [31:0] x, input int fb,
                                          output logic o, output int k);
        logic   sgn;
        int     ex, e, ef, s;
        longint m, mag, g;
        sgn = x[31];
        ex  = int'(x[30:23]);
        o   = 1'b0;
        k   = 0;
        if (ex == 0) return 32'd0;
        if (ex == 255) begin
            o = 1'b1;
            return (x[22:0] != 0 || !sgn) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
        e  = ex - 127;
        ef = e + fb;
        if (ef >= 31 && !(sgn && ef == 31 && x[22:0] == 0)) begin
            o = 1'b1;
            return sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        if (ef < -1) return 32'd0;
        s = ef - 23;
        k = (s < 0) ? -s : s;
        m = longint'({1'b1, x[22:0]});
        if (s >= 0) begin
            mag = m << s;
        end else begin
            mag = m >> (-s);
            g   = (m >> (-s - 1)) & 64'd1;
`ifdef FP2FIX_ROUND_EN
            mag = mag + g;
`endif
        end
        return sgn ? 32'(-mag) : 32'(mag);
    endfunction

    task automatic pop_check(input int d, input sb_t e);
        chk($sformatf("d%0d int_out", d), iout[d], e.res);
        chk($sformatf("d%0d ovf", d), {31'd0, ovf[d]}, {31'd0, e.ovf});
        chk($sformatf("d%0d done cycle", d), 32'(cyc), 32'(e.cyc));
        last_res[d] = e.res;
    endtask

    // Scoreboard monitors: compare each done against the oldest expected entry.
    always @(negedge clk) begin
        if (done[0]) begin
            if (q0.size() == 0) begin
                n_total++;
                $error("FAIL d0 unexpected done: observed 1 expected 0");
            end else pop_check(0, q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (done[1]) begin
            if (q1.size() == 0) begin
                n_total++;
                $error("FAIL d1 unexpected done: observed 1 expected 0");
            end else pop_check(1, q1.pop_front());
        end
    end

    function automatic sb_t make_exp(input int d, input logic [31:0] x);
        sb_t  e;
        logic o;
        int   k;
        e.res = model(x, (d == 0) ? 0 : 8, o, k);
        e.ovf = o;
        e.cyc = cyc + 1 + 3 + k;
        return e;
    endfunction

    task automatic push(input int d, input sb_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Issue one request on a negedge; num_in is scrambled afterwards and must be ignored.
    task automatic convert(input int d, input logic [31:0] x);
        int t = 0;
        while (busy[d] && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        push(d, make_exp(d, x));
        num[d]   = x;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        num[d]   = $urandom;
    endtask

    task automatic wait_done(input int d);
        int t = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (((d == 0) ? q0.size() : q1.size()) != 0) begin
            n_total++;
            $error("FAIL d%0d timeout: observed no done expected done", d);
            if (d == 0) q0.delete();
            else q1.delete();
        end else begin
            @(negedge clk);
            chk($sformatf("d%0d done one cycle", d), {31'd0, done[d]}, 32'd0);
            chk($sformatf("d%0d int_out held", d), iout[d], last_res[d]);
        end
    endtask

    task automatic run(input int d, input logic [31:0] x);
        convert(d, x);
        wait_done(d);
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, $sformatf(" d%0d busy", d)}, {31'd0, busy[d]}, 32'd0);
        chk({tag, $sformatf(" d%0d done", d)}, {31'd0, done[d]}, 32'd0);
        chk({tag, $sformatf(" d%0d ovf", d)}, {31'd0, ovf[d]}, 32'd0);
        chk({tag, $sformatf(" d%0d int_out", d)}, iout[d], 32'd0);
    endtask

    initial begin
        logic [31:0] x;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            num[d]   = '0;
            last_res[d] = '0;
        end
        repeat (3) @(negedge clk);
        chk_idle(0, "reset");
        chk_idle(1, "reset");
        rst = 1'b1;

        run(0, 32'h3F80_0000);  // 1.0, k=23
        run(0, 32'hC020_0000);  // -2.5
        run(0, 32'h4F32_D05E);  // 3e9 saturates
        run(0, 32'hCF00_0000);  // -2^31 exact
        run(0, 32'h7FC0_0000);  // NaN
        run(0, 32'h3E80_0000);  // 0.25 flushes
        run(0, 32'hFF80_0000);  // -Inf
        run(0, 32'h0000_0000);  // zero
        run(0, 32'h3F00_0000);  // 0.5, e+FRAC_BITS == -1
        run(0, 32'h4B00_0000);  // 2^23, k=0
        run(0, 32'hCF00_0001);  // just below -2^31 saturates

        // 1.5 with FRAC_BITS=8, start re-pulsed while busy.
        convert(1, 32'h3FC0_0000);
        start[1] = 1'b1;
        num[1]   = 32'h4000_0000;
        @(negedge clk);
        start[1] = 1'b0;
        wait_done(1);
        repeat (30) @(negedge clk);
        run(1, 32'hBFC0_0000);  // -1.5
        run(1, 32'h3B80_0000);  // 2^-8 -> 1 LSB
        run(1, 32'h4B00_0000);  // 2^23 << 8 saturates

        // Reset during SHIFT, with start held across the reset edge.
        convert(0, 32'h3F80_0000);
        repeat (5) @(negedge clk);
        rst      = 1'b0;
        start[0] = 1'b1;
        num[0]   = 32'h4040_0000;
        @(negedge clk);
        q0.delete();
        chk_idle(0, "midreset");
        @(negedge clk);
        chk({"reset start d0 busy"}, {31'd0, busy[0]}, 32'd0);
        // start still high: first edge with rst=1 accepts it.
        rst = 1'b1;
        push(0, make_exp(0, 32'h4040_0000));
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0);

        for (int i = 0; i < 6; i++) begin
            x = {1'($urandom), 8'($urandom_range(100, 165)), 23'($urandom)};
            run(0, x);
            run(1, x);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_to_fixed.md
FP_TO_FIXED -- requirements
Module: fp_to_fixed

Interface
REQ-001 SHALL have parameter: FRAC_BITS, default 0, number of fractional bits in the signed output, legal range 0..16.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: num_in  input  32  IEEE 754 single-precision operand.
REQ-005 SHALL have port: start  input  1  request, sampled only in IDLE.
REQ-006 SHALL have port: int_out  output  32  two's-complement fixed-point result with FRAC_BITS fraction bits, registered.
REQ-007 SHALL have port: done  output  1  one-cycle pulse, int_out/ovf valid.
REQ-008 SHALL have port: ovf  output  1  saturation flag, registered with int_out.
REQ-009 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL implement FSM IDLE -> UNPACK -> SHIFT -> ROUND -> OUTPUT -> IDLE.
REQ-011 SHALL capture num_in in IDLE on the edge that samples start=1; later num_in changes are ignored until the next accepted start.
REQ-012 SHALL ignore start while busy=1.
REQ-013 UNPACK SHALL compute e = exp-127 (signed, 10 bits), mag = {1,frac}, and shift count s = e-23+FRAC_BITS.
REQ-014 exp==0 (zero/denormal) SHALL give result 0, ovf=0, and SHIFT is skipped.
REQ-015 exp==255 SHALL set ovf=1; +Inf -> 32'h7FFFFFFF, -Inf -> 32'h80000000, NaN -> 32'h7FFFFFFF; SHIFT is skipped.
REQ-016 e+FRAC_BITS >= 31 SHALL saturate by sign with ovf=1; the sole exception is sign=1, e+FRAC_BITS==31, frac==0, which yields 32'h80000000 with ovf=0.
REQ-017 e+FRAC_BITS < -1 SHALL give result 0 with ovf=0, and SHIFT is skipped.
REQ-018 Otherwise SHIFT SHALL shift mag one bit per cycle for k=|s| cycles: left if s>0, right if s<0 (guard bit = last bit shifted out, sticky = OR of earlier bits shifted out).
REQ-019 ROUND SHALL negate the magnitude when sign=1 and place the result into the output register.
REQ-020 Latency: with start sampled at edge 0, done and int_out SHALL be valid after edge 3+k (k=0 for the skipped cases), and done SHALL be high for exactly one cycle.
REQ-021 int_out and ovf SHALL hold their values until the next done.
REQ-022 Right-shift magnitude is always < 2^24, so rounding SHALL never overflow.

Reset
REQ-023 rst=0 at a rising edge SHALL force IDLE, int_out=0, done=0, ovf=0, busy=0, including mid-operation; the in-flight conversion is discarded.
REQ-024 start SHALL be ignored on any edge where rst=0; it is accepted no earlier than the first edge with rst=1.

Configuration
REQ-025 With FP2FIX_ROUND_EN defined, ROUND SHALL add the guard bit to the magnitude before negation (round half away from zero), and e+FRAC_BITS==-1 SHALL round to magnitude 1.
REQ-026 Without FP2FIX_ROUND_EN, ROUND SHALL truncate toward zero (guard and sticky ignored); ports and latency are identical in both builds.

Verification
REQ-027 FRAC_BITS=0, num_in=32'h3F800000 (1.0) -> k=23, done after edge 26, int_out=1, ovf=0.
REQ-028 num_in=32'hC0200000 (-2.5) -> ROUND_EN build: int_out=32'hFFFFFFFD; non-ROUND build: 32'hFFFFFFFE.
REQ-029 num_in=32'h4F32D05E (3e9) -> int_out=32'h7FFFFFFF, ovf=1, done after edge 3; num_in=32'hCF000000 -> int_out=32'h80000000, ovf=0, done after edge 11.
REQ-030 num_in=32'h7FC00000 (NaN) -> int_out=32'h7FFFFFFF, ovf=1; num_in=32'h3E800000 (0.25) -> int_out=0, done after edge 3.
REQ-031 FRAC_BITS=8, num_in=32'h3FC00000 (1.5) -> int_out=32'h00000180; start re-pulsed while busy is ignored.
REQ-032 rst=0 asserted during SHIFT -> next cycle shows busy=0, done=0, int_out=0; a fresh start then converts normally.
